regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 51 +++++
 rtl/regfile_mp.sv | 122 ++++++++++++
 tb/tb_regfile_mp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and write-port priority helper for the multi-port register file.
package regfile_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_NREGS  = 32;
    localparam int MAX_PORTS  = 16;
    localparam int PORT_IDX_W = $clog2(MAX_PORTS);

    // Index of the highest set bit; callers must qualify the result with |hits.
    function automatic logic [PORT_IDX_W-1:0] highest_hit(input logic [MAX_PORTS-1:0] hits);
        logic [PORT_IDX_W-1:0] sel;
        sel = '0;
        for (int j = 0; j < MAX_PORTS; j++) begin
            if (hits[j]) sel = PORT_IDX_W'(j);
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, issue dominates.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0]       busy_reg;
    logic [NREGS-1:0]       busy_next;
    logic [NWR-1:0][AW-1:0] waddr_arr;

    assign waddr_arr = waddr;
    assign busy_vec  = busy_reg;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_track
                logic [NWR-1:0] hit;
                logic           set;
                for (gj = 0; gj < NWR; gj++) begin : g_hit
                    assign hit[gj] = we[gj] && (waddr_arr[gj] == AW'(gi));
                end
                assign set           = issue_valid && (issue_rd == AW'(gi));
                assign busy_next[gi] = set | (busy_reg[gi] & ~(|hit));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with prioritised writes, optional write-to-read
// bypass and an integrated RAW-hazard scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic [NREGS-1:0]    busy_vec
);

    logic [NREGS-1:0][XLEN-1:0] regs_reg;
    logic [NREGS-1:0][XLEN-1:0] regs_next;
    logic [NWR-1:0][AW-1:0]     waddr_arr;
    logic [NWR-1:0][XLEN-1:0]   wdata_arr;
    logic [NRD-1:0][AW-1:0]     raddr_arr;
    logic [NRD-1:0][XLEN-1:0]   rdata_arr;

    assign waddr_arr = waddr;
    assign wdata_arr = wdata;
    assign raddr_arr = raddr;
    assign rdata     = rdata_arr;

    // Data of the highest-index write port among those flagged in hits.
    function automatic logic [XLEN-1:0] pick_wdata(input logic [NWR-1:0] hits,
                                                   input logic [NWR-1:0][XLEN-1:0] data);
        logic [PORT_IDX_W-1:0] sel;
        logic [XLEN-1:0]       d;
        sel = highest_hit(MAX_PORTS'(hits));
        d   = '0;
        for (int j = 0; j < NWR; j++) begin
            if (PORT_IDX_W'(j) == sel) d = data[j];
        end
        return d;
    endfunction

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .waddr       (waddr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy_vec    (busy_vec)
    );

    genvar gi, gj;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign regs_next[gi] = '0;
            end else begin : g_data
                logic [NWR-1:0] hit;
                for (gj = 0; gj < NWR; gj++) begin : g_hit
                    assign hit[gj] = we[gj] && (waddr_arr[gj] == AW'(gi));
                end
                assign regs_next[gi] = (|hit) ? pick_wdata(hit, wdata_arr) : regs_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_reg <= '0;
        end else begin
            regs_reg <= regs_next;
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [XLEN-1:0] data;
            logic            busy;
            if (BYPASS != 0) begin : g_byp
                logic [NWR-1:0] hit;
                logic           is_zero;
                for (gj = 0; gj < NWR; gj++) begin : g_hit
                    assign hit[gj] = we[gj] && (waddr_arr[gj] == raddr_arr[gi]);
                end
                assign is_zero = (ZERO_REG != 0) && (raddr_arr[gi] == '0);
                // Reset already zeroes the state; the gate keeps live write data off the bus.
                always_comb begin
                    data = regs_reg[raddr_arr[gi]];
                    busy = busy_vec[raddr_arr[gi]];
                    if (|hit) begin
                        data = pick_wdata(hit, wdata_arr);
                        busy = issue_valid && (issue_rd == raddr_arr[gi]);
                    end
                    if (!rst_n || is_zero) begin
                        data = '0;
                        busy = 1'b0;
                    end
                end
            end else begin : g_nobyp
                assign data = regs_reg[raddr_arr[gi]];
                assign busy = busy_vec[raddr_arr[gi]];
            end
            assign rdata_arr[gi] = data;
            assign rbusy[gi]     = busy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypassing and registered-only instances share stimulus.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata, rdata_nb;
    logic [NRD-1:0]      rbusy, rbusy_nb;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic [NREGS-1:0]    busy_vec, busy_vec_nb;

    int          n_cmp = 0;
    int          n_mis = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .busy_vec(busy_vec)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .busy_vec(busy_vec_nb)
    );

    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed %h required <none>", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_mis++;
            $error("FAIL %s: observed %h required %h", t, obs, e);
        end
        $display("check %-18s observed %h required %h", t, obs, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we          = '0;
        issue_valid = 1'b0;
    endtask

    task automatic wr(input int port, input logic [AW-1:0] a, input logic [31:0] d);
        we[port]             = 1'b1;
        waddr[port*AW +: AW] = a;
        wdata[port*XLEN +: XLEN] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        raddr = '0; we = '0; waddr = '0; wdata = '0;
        issue_valid = 1'b0; issue_rd = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Activity during reset must neither show on reads nor survive.
        raddr[0 +: AW] = 5'd5;
        wr(0, 5'd5, 32'hCAFE0000);
        issue_valid = 1'b1; issue_rd = 5'd5;
        expect_v("rst_rdata0", 32'h0);
        expect_v("rst_rbusy0", 32'h0);
        expect_v("rst_busy_vec", 32'h0);
        tick(); tick(); #1;
        check(rdata[31:0]);
        check(32'(rbusy[0]));
        check(busy_vec);
        idle();
        rst_n = 1'b1;
        expect_v("post_rst_reg5", 32'h0);
        tick(); #1;
        check(rdata[31:0]);

        // Write reg5 and claim reg6, then async reset mid-cycle.
        wr(0, 5'd5, 32'hDEADBEEF);
        issue_valid = 1'b1; issue_rd = 5'd6;
        expect_v("reg5_written", 32'hDEADBEEF);
        expect_v("busy6_set", 32'h0000_0040);
        tick(); idle(); #1;
        check(rdata[31:0]);
        check(busy_vec);
        rst_n = 1'b0;
        expect_v("async_rst_rdata", 32'h0);
        expect_v("async_rst_busy", 32'h0);
        expect_v("async_rst_nb", 32'h0);
        #1;
        check(rdata[31:0]);
        check(busy_vec);
        check(rdata_nb[31:0]);
        tick(); rst_n = 1'b1; tick();

        // Same-cycle bypass on port 0.
        raddr[0 +: AW] = 5'd3;
        wr(0, 5'd3, 32'h12345678);
        expect_v("bypass_rd0", 32'h12345678);
        expect_v("nobypass_rd0", 32'h0);
        #2;
        check(rdata[31:0]);
        check(rdata_nb[31:0]);
        tick(); idle();
        expect_v("persist_rd0", 32'h12345678);
        expect_v("persist_nb_rd0", 32'h12345678);
        #1;
        check(rdata[31:0]);
        check(rdata_nb[31:0]);

        // Write collision: highest port wins.
        raddr[AW +: AW] = 5'd7;
        wr(0, 5'd7, 32'hAAAA0000);
        wr(1, 5'd7, 32'h5555FFFF);
        expect_v("collide_bypass", 32'h5555FFFF);
        #2;
        check(rdata[63:32]);
        tick(); idle();
        expect_v("collide_reg7", 32'h5555FFFF);
        expect_v("collide_nb_reg7", 32'h5555FFFF);
        #1;
        check(rdata[63:32]);
        check(rdata_nb[63:32]);

        // Issue reg9, three idle cycles, then writeback.
        raddr[0 +: AW] = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        expect_v("issue9_no_fwd", 32'h0);
        #2;
        check(32'(rbusy[0]));
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            expect_v("idle_rbusy9", 32'h1);
            expect_v("idle_nb_rbusy9", 32'h1);
            #1;
            check(32'(rbusy[0]));
            check(32'(rbusy_nb[0]));
            tick();
        end
        wr(0, 5'd9, 32'h00000099);
        expect_v("wb_rbusy9", 32'h0);
        expect_v("wb_nb_rbusy9", 32'h1);
        #2;
        check(32'(rbusy[0]));
        check(32'(rbusy_nb[0]));
        tick(); idle();
        expect_v("wb_busy_vec9", 32'h0);
        expect_v("wb_reg9", 32'h00000099);
        #1;
        check(32'(busy_vec[9]));
        check(rdata[31:0]);

        // Issue and writeback of reg4 together: data lands, busy stays.
        raddr[AW +: AW] = 5'd4;
        issue_valid = 1'b1; issue_rd = 5'd4;
        wr(0, 5'd4, 32'h00000001);
        expect_v("iss_wb_rbusy4", 32'h1);
        expect_v("iss_wb_rdata4", 32'h1);
        #2;
        check(32'(rbusy[1]));
        check(rdata[63:32]);
        tick(); idle();
        expect_v("iss_wb_reg4", 32'h1);
        expect_v("iss_wb_busy4", 32'h1);
        #1;
        check(rdata[63:32]);
        check(32'(busy_vec[4]));

        // Duplicate issue to reg11 is cleared by a single writeback.
        raddr[0 +: AW] = 5'd11;
        issue_valid = 1'b1; issue_rd = 5'd11;
        tick(); tick(); idle();
        expect_v("dup_busy_vec", 32'h0000_0810);
        #1;
        check(busy_vec);
        wr(1, 5'd11, 32'h0000000B);
        tick(); idle();
        expect_v("dup_cleared", 32'h0000_0010);
        expect_v("dup_reg11", 32'h0000000B);
        #1;
        check(busy_vec);
        check(rdata[31:0]);

        // Register 0 ignores writes and issues.
        raddr[0 +: AW] = 5'd0;
        wr(0, 5'd0, 32'hFFFFFFFF);
        wr(1, 5'd0, 32'hFFFFFFFF);
        issue_valid = 1'b1; issue_rd = 5'd0;
        expect_v("zero_byp_rdata", 32'h0);
        expect_v("zero_byp_rbusy", 32'h0);
        #2;
        check(rdata[31:0]);
        check(32'(rbusy[0]));
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            expect_v("zero_rdata", 32'h0);
            expect_v("zero_rbusy", 32'h0);
            expect_v("zero_busy_vec0", 32'h0);
            expect_v("zero_nb_rdata", 32'h0);
            #1;
            check(rdata[31:0]);
            check(32'(rbusy[0]));
            check(32'(busy_vec[0]));
            check(rdata_nb[31:0]);
            tick();
        end

        if (exp_q.size() != 0) begin
            n_mis++;
            $error("FAIL scoreboard_leftover: observed %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
